// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: register scoreboard, mul/div wait, mispredict redirect.
// Optional IDCTRL_FWD_EN: source RAW stalls only on load-use against the load in EX.
module id_issue_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_r1_en,
  input  logic [4:0]  id_r1_addr,
  input  logic        id_r2_en,
  input  logic [4:0]  id_r2_addr,
  input  logic        id_rw_en,
  input  logic [4:0]  id_rw_addr,
  input  logic        id_is_muldiv,
  input  logic        id_predict_miss,
  input  logic [31:0] id_redirect_pc,
  input  logic        ex_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        md_done,
`ifdef IDCTRL_FWD_EN
  input  logic        ex_ld_valid,
  input  logic [4:0]  ex_ld_addr,
`endif
  output logic        id_issue,
  output logic        id_stall,
  output logic        if_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        sb_err
);

  // state    | meaning
  // RUN      | normal issue
  // MD_WAIT  | mul/div busy, issue blocked until cycle after md_done
  // REDIRECT | front end refilling after mispredict, issue blocked
  typedef enum logic [1:0] {RUN, MD_WAIT, REDIRECT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [2:0]       flush_cnt;
  logic [CNT_W-1:0] cnt [NUM_REGS];

  logic src1_haz, src2_haz, waw_haz, hazard;
  logic inc, dec;

`ifdef IDCTRL_FWD_EN
  assign src1_haz = id_r1_en && id_r1_addr != 5'd0 && ex_ld_valid && id_r1_addr == ex_ld_addr;
  assign src2_haz = id_r2_en && id_r2_addr != 5'd0 && ex_ld_valid && id_r2_addr == ex_ld_addr;
`else
  assign src1_haz = id_r1_en && id_r1_addr != 5'd0 && cnt[id_r1_addr] != '0;
  assign src2_haz = id_r2_en && id_r2_addr != 5'd0 && cnt[id_r2_addr] != '0;
`endif
  assign waw_haz  = id_rw_en && id_rw_addr != 5'd0 && cnt[id_rw_addr] == CNT_MAX;
  assign hazard   = src1_haz || src2_haz || waw_haz;

  assign id_issue = id_valid && ex_ready && !hazard && state == RUN;
  assign id_stall = id_valid && !id_issue;

  assign inc = id_issue && id_rw_en && id_rw_addr != 5'd0;
  assign dec = wb_valid && wb_addr != 5'd0;

  // Counters never wrap upward: WAW saturation blocks issue at CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (inc && id_rw_addr == 5'(i) && !(dec && wb_addr == 5'(i))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec && wb_addr == 5'(i) && !(inc && id_rw_addr == 5'(i))) begin
          if (cnt[i] == '0) sb_err <= 1'b1;
          else              cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      flush_cnt      <= 3'd0;
      redirect_valid <= 1'b0;
      if_flush       <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= 1'b0;
      if_flush       <= 1'b0;
      case (state)
        RUN: begin
          if (id_issue && id_predict_miss) begin
            state          <= REDIRECT;
            flush_cnt      <= 3'(FLUSH_CYCLES - 1);
            redirect_valid <= 1'b1;
            if_flush       <= 1'b1;
            redirect_pc    <= id_redirect_pc;
          end else if (id_issue && id_is_muldiv) begin
            state <= MD_WAIT;
          end
        end
        REDIRECT: begin
          if (flush_cnt == 3'd0) state <= RUN;
          else                   flush_cnt <= flush_cnt - 3'd1;
        end
        MD_WAIT: begin
          if (md_done) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
Issue controller for the decode stage. It decides each cycle whether the instruction held in ID may issue to EX. It keeps a per-register scoreboard of in-flight writes, stalls on RAW/WAW hazards and busy multi-cycle mul/div, and sequences front-end flush/redirect after a branch mispredict. It sits between the decoder outputs, the EX/WB stages and the fetch stage.

Parameters:
NUM_REGS, 32, architectural GPR count; r0 is never tracked
CNT_W, 2, width of per-register in-flight counter (max 2^CNT_W-1 writers)
FLUSH_CYCLES, 1, cycles ID issue is blocked after a redirect (1..7)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a valid decoded instruction
id_r1_en  in  1  source 1 read enable
id_r1_addr  in  5  source 1 register
id_r2_en  in  1  source 2 read enable
id_r2_addr  in  5  source 2 register
id_rw_en  in  1  instruction writes a register
id_rw_addr  in  5  destination register
id_is_muldiv  in  1  instruction uses the multi-cycle mul/div unit
id_predict_miss  in  1  decoder branch resolution disagrees with the fetch prediction
id_redirect_pc  in  32  correct next PC for a mispredicted branch
ex_ready  in  1  EX accepts an instruction this cycle
wb_valid  in  1  a register write retires this cycle
wb_addr  in  5  retiring destination
md_done  in  1  mul/div unit finished (1-cycle pulse)
id_issue  out  1  instruction leaves ID this cycle
id_stall  out  1  id_valid & ~id_issue
if_flush  out  1  squash IF/ID contents
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  32  redirect target
sb_err  out  1  sticky: writeback to a register with a zero counter

Behaviour:
- Reset (async, rst_n=0): all counters 0, state RUN, redirect_valid=0, redirect_pc=0, if_flush=0, sb_err=0. id_issue/id_stall are combinational and read 0 while id_valid=0.
- hazard = (r1_en & r1_addr!=0 & cnt[r1_addr]!=0) | (r2_en & r2_addr!=0 & cnt[r2_addr]!=0) | (rw_en & rw_addr!=0 & cnt[rw_addr]==max).
- id_issue = id_valid & ex_ready & ~hazard & state==RUN. Combinational, zero-cycle latency.
- Counter update (posedge): inc = id_issue & rw_en & rw_addr!=0; dec = wb_valid & wb_addr!=0.
  - Same register with inc and dec together: unchanged.
  - dec on a zero counter: counter stays 0, sb_err set until reset.
  - Writes to r0: ignored.
- A writeback in the same cycle does not clear a hazard. Issue occurs the cycle after the counter reaches 0; there is no WB->ID bypass.
- FSM states: RUN, MD_WAIT, REDIRECT.
  - RUN -> REDIRECT when id_issue & id_predict_miss. Next cycle: redirect_valid=1 and if_flush=1 for exactly 1 cycle; redirect_pc is captured from id_redirect_pc and held until the next redirect.
  - RUN -> MD_WAIT when id_issue & id_is_muldiv & ~id_predict_miss.
  - REDIRECT: blocks issue for FLUSH_CYCLES cycles (down-counter), then -> RUN.
  - MD_WAIT: blocks issue; -> RUN in the cycle after md_done=1. md_done arriving in RUN or REDIRECT is ignored.
  - Both predict_miss and muldiv on issue: REDIRECT only.
- ex_ready=0: no issue and no counter increment; state is unaffected.

Optional Feature:
IDCTRL_FWD_EN
- Defined: extra inputs ex_ld_valid (1) and ex_ld_addr (5) describe a load currently in EX. A source RAW hazard is raised only when ex_ld_valid & src==ex_ld_addr & src!=0 (load-use). Other producers are assumed forwarded. WAW saturation checks remain.
- Undefined: full scoreboard RAW stall as above; the ports are absent.

Test Plan:
- Reset released, issue add r3<-r1,r2 with ex_ready=1 -> id_issue=1, cnt[3]=1; next instr reads r3 -> id_stall=1 until cycle after wb_valid/wb_addr=3.
- Three writers to r5 issued, no WB (CNT_W=2) -> 4th writer to r5 stalled; one WB to r5 -> issues next cycle.
- Branch issues with id_predict_miss=1, id_redirect_pc=0x1c000040 -> next cycle redirect_valid=1, if_flush=1, redirect_pc=0x1c000040; id_issue=0 for FLUSH_CYCLES.
- div issued -> MD_WAIT, ready independent instr stalled; md_done pulse -> issues following cycle.
- wb_valid to r7 with cnt[7]=0 -> sb_err=1, stays set; rst_n low mid-MD_WAIT -> immediate RUN, counters and sb_err cleared.
- IDCTRL_FWD_EN: ex_ld_valid=1, ex_ld_addr=4, ID reads r4 -> stall 1 cycle; ALU producer of r4 -> no stall.
